// File: rtl/siso_pkg.sv
// Shared types and constants for the SISO decoder state-metric units.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package siso_pkg;

    localparam int METRIC_W        = 19;
    localparam int BRANCH_W        = 16;
    localparam int METRIC_INIT_NEG = -128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [BRANCH_W-1:0] b1;
        logic signed [BRANCH_W-1:0] b2;
    } branch_pair_t;

    typedef logic signed [METRIC_W-1:0] metric_t;

    // Sign-extend a branch metric into the metric domain.
    function automatic metric_t sext(input logic signed [BRANCH_W-1:0] x);
        return metric_t'(x);
    endfunction

    // Signed maximum of two wrapped metrics.
    function automatic metric_t smax(input metric_t a, input metric_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_lifo.sv
// Simple dual-port RAM holding branch pairs; written forward, read back in reverse by the caller.
// Latency: 1 cycle synchronous read; read data register holds when rd_en is low.
// Backpressure: none; caller gates rd_en to freeze the read data.
module branch_lifo
    import siso_pkg::*;
#(
    parameter int DEPTH  = 6144,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  branch_pair_t      wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output branch_pair_t      rd_data
);

    branch_pair_t mem [DEPTH];

    // Write port: storage array, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered data, cleared by reset so the pair outputs start at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/beta_backward.sv
// Backward beta recursion: captures a block of branch pairs, replays them in reverse with ACS + normalization.
// Latency: first beta vector two cycles after the last pair is accepted, then one per cycle.
// Backpressure: valid/ready on the output; while stalled, outputs, beta registers and read pointer hold.
module beta_backward
    import siso_pkg::*;
#(
    parameter int DEPTH  = 6144,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_branch,
    input  logic signed [BRANCH_W-1:0] init_branch1,
    input  logic signed [BRANCH_W-1:0] init_branch2,
    input  logic                       last_branch,
    input  logic                       beta_ready,
    output logic signed [METRIC_W-1:0] beta_0,
    output logic signed [METRIC_W-1:0] beta_1,
    output logic signed [METRIC_W-1:0] beta_2,
    output logic signed [METRIC_W-1:0] beta_3,
    output logic signed [METRIC_W-1:0] beta_4,
    output logic signed [METRIC_W-1:0] beta_5,
    output logic signed [METRIC_W-1:0] beta_6,
    output logic signed [METRIC_W-1:0] beta_7,
    output logic signed [BRANCH_W-1:0] br1_out,
    output logic signed [BRANCH_W-1:0] br2_out,
    output logic                       valid_beta,
    output logic                       last_beta,
    output logic                       busy,
    output logic                       protocol_err
);

    // ptr counts stored pairs; it needs one extra bit because a full block holds DEPTH entries.
    localparam int PTR_W = ADDR_W + 1;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    metric_t            b_reg   [8];
    metric_t            beta_q  [8];
    metric_t            n_acs   [8];
    metric_t            acs_nrm [8];
    metric_t            e1;
    metric_t            e2;
    branch_pair_t       rd_data;
    branch_pair_t       wr_data;
    logic               accept;
    logic               at_end;
    logic               blk_end;
    logic               hs;
    logic               drain_done;
    logic               rd_en;
    logic               wr_en;

    assign wr_data    = '{b1: init_branch1, b2: init_branch2};
    assign hs         = valid_beta & beta_ready;
    assign drain_done = hs & last_beta;
    // ptr is zero in IDLE, so writing at ptr covers both the first pair and the FILL pairs.
    assign accept     = valid_branch && (state != ST_DRAIN);
    assign at_end     = (ptr == PTR_W'(DEPTH - 1));
    // A write into the final LIFO slot closes the block even without last_branch.
    assign blk_end    = accept && (last_branch || at_end);
    // Issue a read when the output slot is empty or is being consumed this cycle.
    assign rd_en      = (state == ST_DRAIN) && (ptr != '0) && (!valid_beta || beta_ready);

    branch_lifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_lifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (ptr[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (ADDR_W'(ptr - 1'b1)),
        .rd_data (rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: collect a block, then drain it until the last vector is handed off.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)     state_nxt = blk_end ? ST_DRAIN : ST_FILL;
            ST_FILL:  if (blk_end)    state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy  = (state == ST_DRAIN);
        wr_en = accept;
    end

    // Write/read pointer: counts up while filling, down while draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr + 1'b1;
        end else if (rd_en) begin
            ptr <= ptr - 1'b1;
        end
    end

    // Output handshake flags; the vector read from address 0 is the last of the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_beta <= 1'b0;
            last_beta  <= 1'b0;
        end else if (rd_en) begin
            valid_beta <= 1'b1;
            last_beta  <= (ptr == PTR_W'(1));
        end else if (hs) begin
            valid_beta <= 1'b0;
            last_beta  <= 1'b0;
        end
    end

    // Sticky protocol error: pair arriving during drain, or block forced closed at the LIFO end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if ((valid_branch && state == ST_DRAIN) || (accept && at_end && !last_branch)) begin
            protocol_err <= 1'b1;
        end
    end

    // ACS butterflies on the pair currently presented, then normalize against state 0.
    always_comb begin
        e1         = sext(rd_data.b1);
        e2         = sext(rd_data.b2);
        n_acs[0]   = smax(b_reg[0] + e1, b_reg[4] - e1);
        n_acs[1]   = smax(b_reg[0] - e1, b_reg[4] + e1);
        n_acs[2]   = smax(b_reg[1] - e2, b_reg[5] + e2);
        n_acs[3]   = smax(b_reg[1] + e2, b_reg[5] - e2);
        n_acs[4]   = smax(b_reg[2] + e2, b_reg[6] - e2);
        n_acs[5]   = smax(b_reg[2] - e2, b_reg[6] + e2);
        n_acs[6]   = smax(b_reg[3] - e1, b_reg[7] + e1);
        n_acs[7]   = smax(b_reg[3] + e1, b_reg[7] - e1);
        for (int i = 0; i < 8; i++) begin
            acs_nrm[i] = n_acs[i] - n_acs[0];
        end
    end

    // Beta state: advances on each handshake, reloads the terminated-trellis vector when the block ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_reg[0] <= '0;
            for (int i = 1; i < 8; i++) b_reg[i] <= metric_t'(METRIC_INIT_NEG);
        end else if (drain_done) begin
            b_reg[0] <= '0;
            for (int i = 1; i < 8; i++) b_reg[i] <= metric_t'(METRIC_INIT_NEG);
        end else if (hs) begin
            for (int i = 0; i < 8; i++) b_reg[i] <= acs_nrm[i];
        end
    end

    // Output vector register: captures the beta that pairs with the pair being read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) beta_q[i] <= '0;
        end else if (rd_en) begin
            for (int i = 0; i < 8; i++) beta_q[i] <= hs ? acs_nrm[i] : b_reg[i];
        end
    end

    assign beta_0  = beta_q[0];
    assign beta_1  = beta_q[1];
    assign beta_2  = beta_q[2];
    assign beta_3  = beta_q[3];
    assign beta_4  = beta_q[4];
    assign beta_5  = beta_q[5];
    assign beta_6  = beta_q[6];
    assign beta_7  = beta_q[7];
    assign br1_out = rd_data.b1;
    assign br2_out = rd_data.b2;

endmodule

// File: tb/tb_beta_backward.sv
// Self-checking bench for beta_backward with a reverse-order reference model.
// Latency: n/a.
// Backpressure: beta_ready driven high or pseudo-randomly.
module tb_beta_backward;
    import siso_pkg::*;

    typedef struct packed {
        logic [7:0][18:0] beta;
        logic [15:0]      b1;
        logic [15:0]      b2;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               valid_branch, last_branch, beta_ready;
    logic signed [15:0] init_branch1, init_branch2;
    logic signed [18:0] m_beta [8];
    logic signed [15:0] m_br1, m_br2;
    logic               m_valid, m_last, m_busy, m_perr;

    logic               s_valid_branch, s_last_branch, s_beta_ready;
    logic signed [18:0] s_beta [8];
    logic signed [15:0] s_br1, s_br2;
    logic               s_valid, s_last, s_busy, s_perr;

    beta_backward dut (
        .clk(clk), .rst(rst), .valid_branch(valid_branch),
        .init_branch1(init_branch1), .init_branch2(init_branch2),
        .last_branch(last_branch), .beta_ready(beta_ready),
        .beta_0(m_beta[0]), .beta_1(m_beta[1]), .beta_2(m_beta[2]), .beta_3(m_beta[3]),
        .beta_4(m_beta[4]), .beta_5(m_beta[5]), .beta_6(m_beta[6]), .beta_7(m_beta[7]),
        .br1_out(m_br1), .br2_out(m_br2), .valid_beta(m_valid), .last_beta(m_last),
        .busy(m_busy), .protocol_err(m_perr)
    );

    beta_backward #(.DEPTH(8)) dut_small (
        .clk(clk), .rst(rst), .valid_branch(s_valid_branch),
        .init_branch1(init_branch1), .init_branch2(init_branch2),
        .last_branch(s_last_branch), .beta_ready(s_beta_ready),
        .beta_0(s_beta[0]), .beta_1(s_beta[1]), .beta_2(s_beta[2]), .beta_3(s_beta[3]),
        .beta_4(s_beta[4]), .beta_5(s_beta[5]), .beta_6(s_beta[6]), .beta_7(s_beta[7]),
        .br1_out(s_br1), .br2_out(s_br2), .valid_beta(s_valid), .last_beta(s_last),
        .busy(s_busy), .protocol_err(s_perr)
    );

    bit   sel = 1'b0;        // 0: observe main DUT, 1: observe DEPTH=8 DUT
    bit   rand_ready = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t got_q[$];
    exp_t ref_log[$];

    logic cv, cr, cbusy;
    assign cv    = sel ? s_valid : m_valid;
    assign cr    = sel ? s_beta_ready : beta_ready;
    assign cbusy = sel ? s_busy : m_busy;

    function automatic exp_t snap();
        exp_t e;
        for (int i = 0; i < 8; i++) e.beta[i] = sel ? s_beta[i] : m_beta[i];
        e.b1   = sel ? s_br1 : m_br1;
        e.b2   = sel ? s_br2 : m_br2;
        e.last = sel ? s_last : m_last;
        return e;
    endfunction

    function automatic int wrap19(input int x);
        logic [18:0] t;
        t = x[18:0];
        return int'($signed(t));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: outputs in reverse order; each output shows the current beta, then beta steps with that pair.
    task automatic model_block(input logic [31:0] pairs[$]);
        int   bt[8];
        int   nn[8];
        int   kk, b1, b2;
        exp_t e;
        kk = pairs.size();
        for (int i = 0; i < 8; i++) bt[i] = (i == 0) ? 0 : -128;
        for (int n = 0; n < kk; n++) begin
            b1 = int'($signed(pairs[kk-1-n][31:16]));
            b2 = int'($signed(pairs[kk-1-n][15:0]));
            for (int i = 0; i < 8; i++) e.beta[i] = 19'(bt[i]);
            e.b1   = pairs[kk-1-n][31:16];
            e.b2   = pairs[kk-1-n][15:0];
            e.last = (n == kk - 1);
            exp_q.push_back(e);
            nn[0] = max2(wrap19(bt[0] + b1), wrap19(bt[4] - b1));
            nn[1] = max2(wrap19(bt[0] - b1), wrap19(bt[4] + b1));
            nn[2] = max2(wrap19(bt[1] - b2), wrap19(bt[5] + b2));
            nn[3] = max2(wrap19(bt[1] + b2), wrap19(bt[5] - b2));
            nn[4] = max2(wrap19(bt[2] + b2), wrap19(bt[6] - b2));
            nn[5] = max2(wrap19(bt[2] - b2), wrap19(bt[6] + b2));
            nn[6] = max2(wrap19(bt[3] - b1), wrap19(bt[7] + b1));
            nn[7] = max2(wrap19(bt[3] + b1), wrap19(bt[7] - b1));
            for (int i = 0; i < 8; i++) bt[i] = wrap19(nn[i] - nn[0]);
        end
    endtask

    task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
        end
    endtask

    // Per-cycle compare of the observed DUT against the model queue (stalls re-check the same entry).
    always @(negedge clk) begin
        exp_t g;
        if (!rst && cv) begin
            g = snap();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%h", g);
                if (cr) got_q.push_back(g);
            end else begin
                if (g !== exp_q[0]) begin
                    errors++;
                    $display("FAIL beta_out got=%h expected=%h", g, exp_q[0]);
                end
                if (cr) begin
                    got_q.push_back(g);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Ready generator.
    initial begin
        beta_ready   = 1'b1;
        s_beta_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            beta_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic send_block(input bit to_small, input logic [31:0] pairs[$], input bit use_last, input bit check_lat);
        for (int i = 0; i < pairs.size(); i++) begin
            @(posedge clk);
            #1;
            init_branch1 = pairs[i][31:16];
            init_branch2 = pairs[i][15:0];
            if (to_small) begin
                s_valid_branch = 1'b1;
                s_last_branch  = use_last && (i == pairs.size() - 1);
            end else begin
                valid_branch = 1'b1;
                last_branch  = use_last && (i == pairs.size() - 1);
            end
        end
        @(posedge clk);
        #1;
        valid_branch   = 1'b0;
        last_branch    = 1'b0;
        s_valid_branch = 1'b0;
        s_last_branch  = 1'b0;
        if (check_lat) begin
            @(negedge clk);
            chk("busy_at_t+1", 32'(m_busy), 1);
            chk("valid_low_at_t+1", 32'(m_valid), 0);
            @(negedge clk);
            chk("valid_at_t+2", 32'(m_valid), 1);
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cbusy) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s drain_timeout remaining=%0d expected=0", nm, exp_q.size());
        end
    endtask

    function automatic logic [31:0] rnd_pair();
        logic [31:0] p;
        p = $urandom;
        return p;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] p;
        int          lit1[8];
        int          n;

        rst = 1'b1;
        valid_branch = 1'b0; last_branch = 1'b0;
        s_valid_branch = 1'b0; s_last_branch = 1'b0;
        init_branch1 = '0; init_branch2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_perr", 32'(m_perr), 0);
        for (int i = 0; i < 8; i++) chk("rst_beta", 32'(m_beta[i]), 0);
        chk("rst_br1", 32'(m_br1), 0);
        chk("rst_br2", 32'(m_br2), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // K=4, constant pair (10,0), ready high.
        q = {};
        for (int i = 0; i < 4; i++) q.push_back({16'd10, 16'd0});
        model_block(q);
        got_q.delete();
        send_block(0, q, 1, 1);
        wait_drain("k4");
        chk("k4_count", got_q.size(), 4);
        lit1 = '{0, -20, -138, -138, -138, -138, -128, -128};
        if (got_q.size() == 4) begin
            for (int i = 0; i < 8; i++) chk("k4_out0", 32'($signed(got_q[0].beta[i])), (i == 0) ? 0 : -128);
            for (int i = 0; i < 8; i++) chk("k4_out1", 32'($signed(got_q[1].beta[i])), lit1[i]);
            for (int i = 0; i < 4; i++) chk("k4_last", 32'(got_q[i].last), (i == 3) ? 1 : 0);
            chk("k4_br1", 32'($signed(got_q[0].b1)), 10);
        end

        // K=16 random, ready high then the same block with random ready.
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(rnd_pair());
        model_block(q);
        got_q.delete();
        send_block(0, q, 1, 1);
        wait_drain("k16_ready");
        ref_log = got_q;
        rand_ready = 1'b1;
        model_block(q);
        got_q.delete();
        send_block(0, q, 1, 1);
        wait_drain("k16_stall");
        rand_ready = 1'b0;
        @(posedge clk);
        chk("k16_count", got_q.size(), ref_log.size());
        if (got_q.size() == ref_log.size()) begin
            for (int i = 0; i < ref_log.size(); i++) begin
                checks++;
                if (got_q[i] !== ref_log[i]) begin
                    errors++;
                    $display("FAIL k16_same_seq idx=%0d got=%h expected=%h", i, got_q[i], ref_log[i]);
                end
            end
        end

        // K=1: single output with init vector and pair (5,-3).
        p = {16'd5, 16'hFFFD};
        q = {p};
        model_block(q);
        got_q.delete();
        send_block(0, q, 1, 1);
        wait_drain("k1");
        chk("k1_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("k1_br1", 32'($signed(got_q[0].b1)), 5);
            chk("k1_br2", 32'($signed(got_q[0].b2)), -3);
            chk("k1_last", 32'(got_q[0].last), 1);
            chk("k1_beta7", 32'($signed(got_q[0].beta[7])), -128);
        end

        // DEPTH=8 instance, 10 pairs without last: 8 kept, 2 dropped.
        sel = 1'b1;
        q = {};
        for (int i = 0; i < 10; i++) q.push_back(rnd_pair());
        begin
            logic [31:0] q8[$];
            q8 = q[0:7];
            model_block(q8);
        end
        got_q.delete();
        send_block(1, q, 0, 0);
        wait_drain("depth8");
        chk("depth8_count", got_q.size(), 8);
        chk("depth8_perr", 32'(s_perr), 1);
        sel = 1'b0;
        chk("main_perr_clean", 32'(m_perr), 0);

        // Reset on the 3rd output of a K=8 block, then a fresh K=4 block.
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(rnd_pair());
        model_block(q);
        got_q.delete();
        send_block(0, q, 1, 1);
        n = 0;
        while (got_q.size() < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pre_rst_two_outputs", got_q.size(), 2);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(m_valid), 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_valid", 32'(m_valid), 0);
        chk("midrst_last", 32'(m_last), 0);
        chk("midrst_busy", 32'(m_busy), 0);
        chk("midrst_beta1", 32'(m_beta[1]), 0);
        chk("midrst_br1", 32'(m_br1), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(rnd_pair());
        model_block(q);
        got_q.delete();
        send_block(0, q, 1, 1);
        wait_drain("post_rst_k4");
        chk("post_rst_count", got_q.size(), 4);

        // valid_branch pulsed during drain: dropped, error flagged, data unaffected.
        chk("perr_cleared", 32'(m_perr), 0);
        rand_ready = 1'b1;
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(rnd_pair());
        model_block(q);
        got_q.delete();
        send_block(0, q, 1, 1);
        @(posedge clk);
        #1;
        valid_branch = 1'b1; last_branch = 1'b1;
        init_branch1 = 16'h7FFF; init_branch2 = 16'h8000;
        @(posedge clk);
        #1;
        valid_branch = 1'b0; last_branch = 1'b0;
        wait_drain("drain_pulse");
        rand_ready = 1'b0;
        chk("drain_pulse_count", got_q.size(), 8);
        chk("drain_pulse_perr", 32'(m_perr), 1);
        @(negedge clk);
        chk("idle_after_drain", 32'(m_busy), 0);
        chk("no_stray_output", 32'(m_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
